quiz_round_ctrl: RTL and testbench

//   Round controller for the buzzer quiz game; sits upstream of the countdown timer and also consumes its output.

---
 rtl/quiz_round_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_quiz_round_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl: round controller for the buzzer quiz game.
//   Arms the countdown timer for the buzz window and then the answer window.
//   Arbitrates four player buzzers, lowest index first, and records the host's
//   judgement of the winner's answer.
// Optional feature macro: QUIZ_FOUL_LOCKOUT_EN (locks out players who buzz while IDLE).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   host_start/ok/bad/clear         raw host buttons (synchronised in here)
//   player_btn[3:0]                 raw player buzzers, bit i = player i
//   timer_left[3:0]                 seconds remaining, from the countdown timer
//   timer_start, timer_seconds[3:0] timer load strobe and load value
//   winner[1:0], winner_valid       latched buzzing player
//   result[1:0]                     00 none, 01 correct, 10 wrong, 11 timeout
//   busy                            high outside IDLE and DONE
//   lockout[3:0]                    per-player foul lockout
module quiz_round_ctrl #(
    parameter logic [3:0]  BUZZ_SECS   = 4'd9,
    parameter logic [3:0]  ANSWER_SECS = 4'd5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       host_start,
    input  logic       host_ok,
    input  logic       host_bad,
    input  logic       host_clear,
    input  logic [3:0] player_btn,
    input  logic [3:0] timer_left,
    output logic       timer_start,
    output logic [3:0] timer_seconds,
    output logic [1:0] winner,
    output logic       winner_valid,
    output logic [1:0] result,
    output logic       busy,
    output logic [3:0] lockout
);

    localparam int unsigned NBTN = 8;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ARM_B, ST_BUZZ, ST_ARM_A, ST_ANSWER, ST_DONE
    } state_t;

    state_t          r_state;
    logic            r_timer_start;
    logic [3:0]      r_timer_seconds;
    logic [1:0]      r_winner;
    logic            r_winner_valid;
    logic [1:0]      r_result;
    logic            r_busy;

    logic [NBTN-1:0] w_raw;
    logic [NBTN-1:0] r_sync [SYNC_STAGES];
    logic [NBTN-1:0] r_prev;
    logic [NBTN-1:0] r_edge;

    logic            w_start_e, w_ok_e, w_bad_e, w_clr_e;
    logic [3:0]      w_ply_e;
    logic [3:0]      w_lock;
    logic [3:0]      w_cand;
    logic [1:0]      w_first_idx;
    logic            w_left_zero;
    logic            w_to_done;

    assign w_raw = {player_btn, host_clear, host_bad, host_ok, host_start};

    // Synchroniser chain followed by a registered rising-edge detector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) r_sync[i] <= '0;
            r_prev <= '0;
            r_edge <= '0;
        end else begin
            r_sync[0] <= w_raw;
            for (int i = 1; i < int'(SYNC_STAGES); i++) r_sync[i] <= r_sync[i-1];
            r_prev <= r_sync[SYNC_STAGES-1];
            r_edge <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign w_start_e   = r_edge[0];
    assign w_ok_e      = r_edge[1];
    assign w_bad_e     = r_edge[2];
    assign w_clr_e     = r_edge[3];
    assign w_ply_e     = r_edge[7:4];
    assign w_cand      = w_ply_e & ~w_lock;
    assign w_left_zero = (timer_left == 4'd0);

    // Lowest-index eligible buzzer wins a tie
    always_comb begin
        w_first_idx = 2'd0;
        if      (w_cand[0]) w_first_idx = 2'd0;
        else if (w_cand[1]) w_first_idx = 2'd1;
        else if (w_cand[2]) w_first_idx = 2'd2;
        else if (w_cand[3]) w_first_idx = 2'd3;
    end

    // Round ends this cycle (shared with the lockout register)
    assign w_to_done = !w_clr_e &&
        (((r_state == ST_BUZZ) && !(|w_cand) && w_left_zero) ||
         ((r_state == ST_ANSWER) && (w_ok_e || w_bad_e || w_left_zero)));

    // Round FSM; clear outranks every other event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_timer_start   <= 1'b0;
            r_timer_seconds <= 4'd0;
            r_winner        <= 2'd0;
            r_winner_valid  <= 1'b0;
            r_result        <= 2'd0;
            r_busy          <= 1'b0;
        end else begin
            r_timer_start <= 1'b0;
            if (w_clr_e) begin
                r_state        <= ST_IDLE;
                r_winner       <= 2'd0;
                r_winner_valid <= 1'b0;
                r_result       <= 2'd0;
                r_busy         <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start_e) begin
                            r_state         <= ST_ARM_B;
                            r_winner        <= 2'd0;
                            r_winner_valid  <= 1'b0;
                            r_result        <= 2'd0;
                            r_busy          <= 1'b1;
                            r_timer_start   <= 1'b1;
                            r_timer_seconds <= BUZZ_SECS;
                        end
                    end
                    ST_ARM_B: r_state <= ST_BUZZ;
                    ST_BUZZ: begin
                        if (|w_cand) begin
                            r_state         <= ST_ARM_A;
                            r_winner        <= w_first_idx;
                            r_winner_valid  <= 1'b1;
                            r_timer_start   <= 1'b1;
                            r_timer_seconds <= ANSWER_SECS;
                        end else if (w_left_zero) begin
                            r_state  <= ST_DONE;
                            r_result <= 2'b11;
                            r_busy   <= 1'b0;
                        end
                    end
                    ST_ARM_A: r_state <= ST_ANSWER;
                    ST_ANSWER: begin
                        if (w_ok_e || w_bad_e || w_left_zero) begin
                            r_state  <= ST_DONE;
                            r_busy   <= 1'b0;
                            r_result <= w_ok_e ? 2'b01 : (w_bad_e ? 2'b10 : 2'b11);
                        end
                    end
                    ST_DONE: r_state <= ST_DONE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef QUIZ_FOUL_LOCKOUT_EN
    logic [3:0] r_lockout;

    // Early buzzes while IDLE lock the player out of the next buzz window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lockout <= 4'd0;
        end else if (w_to_done || (w_clr_e && (r_state != ST_IDLE))) begin
            r_lockout <= 4'd0;
        end else if ((r_state == ST_IDLE) && !w_clr_e) begin
            r_lockout <= r_lockout | w_ply_e;
        end
    end

    assign w_lock  = r_lockout;
    assign lockout = r_lockout;
`else
    assign w_lock  = 4'd0;
    assign lockout = 4'd0;
`endif

    assign timer_start   = r_timer_start;
    assign timer_seconds = r_timer_seconds;
    assign winner        = r_winner;
    assign winner_valid  = r_winner_valid;
    assign result        = r_result;
    assign busy          = r_busy;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
`timescale 1ns/1ps
module tb_quiz_round_ctrl;

    localparam logic [3:0] BUZZ   = 4'd9;
    localparam logic [3:0] ANSWER = 4'd5;
    localparam logic [3:0] IDLE_LEFT = 4'd7;
`ifdef QUIZ_FOUL_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_start = 1'b0, host_ok = 1'b0, host_bad = 1'b0, host_clear = 1'b0;
    logic [3:0] player_btn = 4'd0;
    logic [3:0] timer_left = IDLE_LEFT;
    logic       timer_start;
    logic [3:0] timer_seconds;
    logic [1:0] winner;
    logic       winner_valid;
    logic [1:0] result;
    logic       busy;
    logic [3:0] lockout;

    int checks = 0;
    int errors = 0;

    // Spec-level model of the visible round outcome
    logic [1:0] m_winner = 2'd0;
    logic       m_valid  = 1'b0;
    logic [1:0] m_result = 2'd0;
    logic [3:0] m_secs   = 4'd0;
    logic [3:0] m_lock   = 4'd0;

    always #5 clk = ~clk;

    quiz_round_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .host_start(host_start), .host_ok(host_ok), .host_bad(host_bad), .host_clear(host_clear),
        .player_btn(player_btn), .timer_left(timer_left),
        .timer_start(timer_start), .timer_seconds(timer_seconds),
        .winner(winner), .winner_valid(winner_valid), .result(result),
        .busy(busy), .lockout(lockout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ts, input logic [3:0] secs,
                             input logic [1:0] win, input logic wv, input logic [1:0] res,
                             input logic bsy, input logic [3:0] lk);
        check({tag, ".timer_start"},   8'(timer_start),   8'(ts));
        check({tag, ".timer_seconds"}, 8'(timer_seconds), 8'(secs));
        check({tag, ".winner"},        8'(winner),        8'(win));
        check({tag, ".winner_valid"},  8'(winner_valid),  8'(wv));
        check({tag, ".result"},        8'(result),        8'(res));
        check({tag, ".busy"},          8'(busy),          8'(bsy));
        check({tag, ".lockout"},       8'(lockout),       8'(lk));
    endtask

    function automatic logic [1:0] lowest(input logic [3:0] m);
        logic [1:0] idx = 2'd0;
        bit found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m[i] && !found) begin
                idx = 2'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // Raise raw buttons for one cycle; afterwards their edge is ready for the next cycle
    task automatic press(input logic [3:0] host, input logic [3:0] players);
        {host_clear, host_bad, host_ok, host_start} = host;
        player_btn = players;
        tick();
        {host_clear, host_bad, host_ok, host_start} = 4'd0;
        player_btn = 4'd0;
        tick();
        tick();
    endtask

    task automatic start_round(input string tag);
        press(4'b0001, 4'd0);
        tick();
        m_winner = 2'd0; m_valid = 1'b0; m_result = 2'd0; m_secs = BUZZ;
        check_all({tag, ".arm_b"}, 1'b1, m_secs, m_winner, m_valid, m_result, 1'b1, m_lock);
        tick();
        check_all({tag, ".buzz"}, 1'b0, m_secs, m_winner, m_valid, m_result, 1'b1, m_lock);
    endtask

    task automatic buzz(input string tag, input logic [3:0] players);
        press(4'd0, players);
        tick();
        m_winner = lowest(players & ~m_lock); m_valid = 1'b1; m_secs = ANSWER;
        check_all({tag, ".arm_a"}, 1'b1, m_secs, m_winner, m_valid, m_result, 1'b1, m_lock);
        tick();
        check_all({tag, ".answer"}, 1'b0, m_secs, m_winner, m_valid, m_result, 1'b1, m_lock);
    endtask

    // kind: 0 ok, 1 bad, 2 ok+bad together, 3 timeout
    task automatic judge(input string tag, input int kind);
        if (kind == 3) begin
            timer_left = 4'd0;
            tick();
            timer_left = IDLE_LEFT;
        end else begin
            press((kind == 0) ? 4'b0010 : (kind == 1) ? 4'b0100 : 4'b0110, 4'd0);
            tick();
        end
        m_result = (kind == 1) ? 2'b10 : (kind == 3) ? 2'b11 : 2'b01;
        m_lock = 4'd0;
        check_all({tag, ".done"}, 1'b0, m_secs, m_winner, m_valid, m_result, 1'b0, m_lock);
        tick();
        check_all({tag, ".hold"}, 1'b0, m_secs, m_winner, m_valid, m_result, 1'b0, m_lock);
    endtask

    task automatic clear_round(input string tag);
        press(4'b1000, 4'd0);
        tick();
        m_winner = 2'd0; m_valid = 1'b0; m_result = 2'd0; m_lock = 4'd0;
        check_all({tag, ".clear"}, 1'b0, m_secs, m_winner, m_valid, m_result, 1'b0, m_lock);
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b0, 4'd0);
        rst_n = 1'b1;
        tick(); tick();
        check_all("post_reset", 1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b0, 4'd0);

        // Player 2 buzzes a few cycles into BUZZ, host accepts
        start_round("r1");
        repeat (3) begin
            tick();
            check("r1.wait.valid", 8'(winner_valid), 8'd0);
        end
        buzz("r1", 4'b0100);
        judge("r1", 0);
        clear_round("r1");

        // Host rejects
        start_round("r2");
        buzz("r2", 4'b0001);
        judge("r2", 1);
        clear_round("r2");

        // ok and bad together: ok wins
        start_round("r3");
        buzz("r3", 4'b1000);
        judge("r3", 2);
        clear_round("r3");

        // Buzz window expires with no buzz
        start_round("r4");
        timer_left = 4'd0;
        tick();
        timer_left = IDLE_LEFT;
        m_result = 2'b11; m_lock = 4'd0;
        check_all("r4.expire", 1'b0, m_secs, 2'd0, 1'b0, m_result, 1'b0, m_lock);
        clear_round("r4");

        // Simultaneous buzz 1 and 3, then answer window expires
        start_round("r5");
        buzz("r5", 4'b1010);
        judge("r5", 3);
        clear_round("r5");

        // Buzz and expiry together: buzz wins; judge and expiry together: judge wins
        start_round("r6");
        press(4'd0, 4'b1000);
        timer_left = 4'd0;
        tick();
        timer_left = IDLE_LEFT;
        m_winner = 2'd3; m_valid = 1'b1; m_secs = ANSWER;
        check_all("r6.buzz_vs_expiry", 1'b1, m_secs, m_winner, m_valid, 2'd0, 1'b1, m_lock);
        tick();
        press(4'b0010, 4'd0);
        timer_left = 4'd0;
        tick();
        timer_left = IDLE_LEFT;
        m_result = 2'b01; m_lock = 4'd0;
        check_all("r6.judge_vs_expiry", 1'b0, m_secs, m_winner, m_valid, m_result, 1'b0, m_lock);
        clear_round("r6");

        // ok and start ignored in BUZZ; clear during ANSWER
        start_round("r7");
        press(4'b0010, 4'd0);
        tick();
        check_all("r7.ok_in_buzz", 1'b0, m_secs, 2'd0, 1'b0, 2'd0, 1'b1, m_lock);
        press(4'b0001, 4'd0);
        tick();
        check_all("r7.start_in_buzz", 1'b0, m_secs, 2'd0, 1'b0, 2'd0, 1'b1, m_lock);
        buzz("r7", 4'b0010);
        clear_round("r7");

        // Player edge landing in ARM_B is ignored
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        player_btn = 4'b0100;
        tick();
        player_btn = 4'd0;
        tick(); tick();
        m_secs = BUZZ;
        check_all("r8.arm_b", 1'b1, m_secs, 2'd0, 1'b0, 2'd0, 1'b1, m_lock);
        tick();
        check_all("r8.blind", 1'b0, m_secs, 2'd0, 1'b0, 2'd0, 1'b1, m_lock);
        tick();
        check_all("r8.blind2", 1'b0, m_secs, 2'd0, 1'b0, 2'd0, 1'b1, m_lock);

        // Asynchronous reset mid-BUZZ
        rst_n = 1'b0;
        #1;
        m_secs = 4'd0; m_lock = 4'd0;
        check_all("r8.async_reset", 1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 1'b0, 4'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick();

        // Foul in IDLE by player 0, then players 0 and 2 buzz
        press(4'd0, 4'b0001);
        tick();
        if (LOCK_EN) m_lock = 4'b0001;
        check("r9.foul_lockout", 8'(lockout), 8'(m_lock));
        start_round("r9");
        buzz("r9", 4'b0101);
        judge("r9", 0);
        clear_round("r9");

        // Randomised rounds
        for (int n = 0; n < 8; n++) begin
            logic [3:0] mask;
            int kind;
            int waitc;
            mask  = 4'($urandom_range(1, 15));
            kind  = int'($urandom_range(0, 3));
            waitc = int'($urandom_range(0, 3));
            timer_left = 4'($urandom_range(1, 15));
            start_round($sformatf("rnd%0d", n));
            repeat (waitc) tick();
            buzz($sformatf("rnd%0d", n), mask);
            judge($sformatf("rnd%0d", n), kind);
            clear_round($sformatf("rnd%0d", n));
            timer_left = IDLE_LEFT;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
